// File: rtl/hb_interp_ctrl.sv
// hb_interp_ctrl: sequencer and coefficient manager for the 4x halfband interpolator.
// Generates the frame and half-rate clock enables and the zero-stuff phase selects.
// Flushes the datapath on start. Holds shadow/active coefficient banks for both stages,
// and applies commits only on frame boundaries.
// Ports:
//   sys_clk, reset        - clock, synchronous active-high reset
//   i_run                 - level; 1 = stream, 0 = stop at the next frame boundary
//   o_sam_clk_en          - 1-cycle pulse per 4-cycle frame (cnt == 3)
//   o_sys_clk2_en         - 1-cycle pulse every 2 cycles (cnt odd)
//   o_up1_sel, o_up2_sel  - zero-stuff selects (0 = pass sample, 1 = insert zero)
//   o_dp_clear            - datapath clear, held for FLUSH_CYC cycles on start
//   o_busy                - sequencer active (PRIME, RUN, STOP)
//   i_cfg_*/o_cfg_ready   - coefficient write port (valid/ready) and commit request
//   o_cfg_err             - pulse after a write to a structurally-zero tap
//   o_hb1_coef/o_hb2_coef - active taps, tap k at [k*WIDTH +: WIDTH]
module hb_interp_ctrl #(
   parameter int unsigned WIDTH     = 18,
   parameter int unsigned NCOEF     = 8,
   parameter int unsigned FLUSH_CYC = 16
) (
   input  logic                   sys_clk,
   input  logic                   reset,
   input  logic                   i_run,
   output logic                   o_sam_clk_en,
   output logic                   o_sys_clk2_en,
   output logic                   o_up1_sel,
   output logic                   o_up2_sel,
   output logic                   o_dp_clear,
   output logic                   o_busy,
   input  logic                   i_cfg_valid,
   output logic                   o_cfg_ready,
   input  logic                   i_cfg_filt,
   input  logic [2:0]             i_cfg_addr,
   input  logic [WIDTH-1:0]       i_cfg_data,
   input  logic                   i_cfg_commit,
   output logic                   o_cfg_err,
   output logic [NCOEF*WIDTH-1:0] o_hb1_coef,
   output logic [NCOEF*WIDTH-1:0] o_hb2_coef
);

   localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StPrime, StRun, StStop} state_e;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [1:0]       r_cnt;
   logic [1:0]       w_cnt_nxt;
   logic [FW-1:0]    r_flush;
   logic             r_stop_req;
   logic             r_pend;
   logic             w_pend_nxt;
   logic             w_busy_run_nxt;
   logic             w_sam_nxt;
   logic             w_wr;
   logic             w_fixed;
   logic             w_wr_ok;
   logic             w_copy;
   logic [WIDTH-1:0] r_sh1  [NCOEF];
   logic [WIDTH-1:0] r_sh2  [NCOEF];
   logic [WIDTH-1:0] r_act1 [NCOEF];
   logic [WIDTH-1:0] r_act2 [NCOEF];
   logic [WIDTH-1:0] w_sh1_nxt [NCOEF];
   logic [WIDTH-1:0] w_sh2_nxt [NCOEF];

   // Default unique taps (0s18); odd taps below the centre are structurally zero.
   function automatic logic [WIDTH-1:0] def_coef(input logic filt, input int k);
      int v;
      case (k)
         0:       v = filt ? -322   : -348;
         2:       v = filt ? 3144   : 3274;
         4:       v = filt ? -15695 : -15925;
         6:       v = filt ? 78408  : 78535;
         7:       v = 131071;
         default: v = 0;
      endcase
      return v[WIDTH-1:0];
   endfunction

   // Sequencer next state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = 2'd0;
      unique case (r_state)
         StIdle: begin
            if (i_run) w_state_nxt = StPrime;
         end
         StPrime: begin
            // A stop requested during the flush still streams exactly one frame.
            if (r_flush == FW'(FLUSH_CYC - 1)) begin
               w_state_nxt = (r_stop_req || !i_run) ? StStop : StRun;
            end
         end
         StRun: begin
            w_cnt_nxt = r_cnt + 2'd1;
            if (!i_run) w_state_nxt = StStop;
         end
         StStop: begin
            w_cnt_nxt = r_cnt + 2'd1;
            if (r_cnt == 2'd3) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign w_busy_run_nxt = (w_state_nxt == StRun) || (w_state_nxt == StStop);
   assign w_sam_nxt      = w_busy_run_nxt && (w_cnt_nxt == 2'd3);

   // Coefficient write / commit
   assign w_wr    = i_cfg_valid && o_cfg_ready;
   assign w_fixed = (i_cfg_addr == 3'd1) || (i_cfg_addr == 3'd3) || (i_cfg_addr == 3'd5);
   assign w_wr_ok = w_wr && !w_fixed;
   // Copy lands on the edge into the sam_clk_en cycle so a frame never mixes banks.
   assign w_copy  = ((r_state == StIdle) && (i_cfg_commit || r_pend)) || (r_pend && w_sam_nxt);

   always_comb begin
      w_sh1_nxt = r_sh1;
      w_sh2_nxt = r_sh2;
      if (w_wr_ok) begin
         if (i_cfg_filt) w_sh2_nxt[i_cfg_addr] = i_cfg_data;
         else            w_sh1_nxt[i_cfg_addr] = i_cfg_data;
      end
   end

   // Pending stays set through the boundary cycle and clears after it.
   always_comb begin
      if (r_state == StIdle)           w_pend_nxt = 1'b0;
      else if (r_pend && o_sam_clk_en) w_pend_nxt = 1'b0;
      else if (i_cfg_commit)           w_pend_nxt = 1'b1;
      else                             w_pend_nxt = r_pend;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_state       <= StIdle;
         r_cnt         <= 2'd0;
         r_flush       <= '0;
         r_stop_req    <= 1'b0;
         r_pend        <= 1'b0;
         o_sam_clk_en  <= 1'b0;
         o_sys_clk2_en <= 1'b0;
         o_up1_sel     <= 1'b0;
         o_up2_sel     <= 1'b0;
         o_dp_clear    <= 1'b0;
         o_busy        <= 1'b0;
         o_cfg_err     <= 1'b0;
         for (int k = 0; k < NCOEF; k++) begin
            r_sh1[k]  <= def_coef(1'b0, k);
            r_sh2[k]  <= def_coef(1'b1, k);
            r_act1[k] <= def_coef(1'b0, k);
            r_act2[k] <= def_coef(1'b1, k);
         end
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_flush       <= (r_state == StPrime) ? r_flush + 1'b1 : '0;
         r_stop_req    <= (r_state == StPrime) && (r_stop_req || !i_run);
         r_pend        <= w_pend_nxt;
         o_sam_clk_en  <= w_sam_nxt;
         o_sys_clk2_en <= w_busy_run_nxt && w_cnt_nxt[0];
         o_up1_sel     <= w_cnt_nxt[1];
         o_up2_sel     <= w_cnt_nxt[0];
         o_dp_clear    <= (w_state_nxt == StPrime);
         o_busy        <= (w_state_nxt != StIdle);
         o_cfg_err     <= w_wr && w_fixed;
         r_sh1         <= w_sh1_nxt;
         r_sh2         <= w_sh2_nxt;
         if (w_copy) begin
            r_act1 <= w_sh1_nxt;
            r_act2 <= w_sh2_nxt;
         end
      end
   end

   assign o_cfg_ready = !r_pend;

   always_comb begin
      for (int k = 0; k < NCOEF; k++) begin
         o_hb1_coef[k*WIDTH +: WIDTH] = r_act1[k];
         o_hb2_coef[k*WIDTH +: WIDTH] = r_act2[k];
      end
   end

endmodule
